// File: rtl/jtkiwi_shram_pkg.sv
// jtkiwi_shram_pkg: shared state encodings and pointer sizing for the shared-RAM arbiter
package jtkiwi_shram_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ACC, ARB_RD} arb_st_t;
  typedef enum logic [1:0] {P_IDLE, P_PEND, P_DONE} port_st_t;
  localparam int MIN_PTR_W = 1;
  function automatic int ptr_w(input int n);
    return $clog2(n) > MIN_PTR_W ? $clog2(n) : MIN_PTR_W;
  endfunction
endpackage

// File: rtl/jtkiwi_shram_rr.sv
// jtkiwi_shram_rr: combinational round-robin pick of the first pending port at or after ptr
module jtkiwi_shram_rr #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  pend,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] idx,
  output logic          any
);
  always_comb begin
    int j;
    j   = 0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      j = j >= N ? j - N : j;
      if (pend[PW'(j)]) idx = PW'(j);
    end
    any = |pend;
  end
endmodule

// File: rtl/jtkiwi_shram_arb.sv
// jtkiwi_shram_arb: N-port round-robin shared-RAM arbiter with embedded single-port RAM
// Define JTKIWI_SHRAM_STATS_EN to count contended cycles on st_dout.
module jtkiwi_shram_arb
  import jtkiwi_shram_pkg::*;
#(
  parameter int NPORTS = 2,
  parameter int AW     = 13,
  parameter int DW     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hold,
  input  logic [NPORTS-1:0]    cs,
  input  logic [NPORTS-1:0]    rnw,
  input  logic [NPORTS*AW-1:0] addr,
  input  logic [NPORTS*DW-1:0] din,
  output logic [NPORTS*DW-1:0] dout,
  output logic [NPORTS-1:0]    ok,
  output logic [7:0]           st_dout
);
  localparam int PW = ptr_w(NPORTS);
  arb_st_t st, st_nx;
  port_st_t pst [NPORTS];
  port_st_t pst_nx [NPORTS];
  logic [PW-1:0] rr_ptr, grant, pick;
  logic any;
  logic [NPORTS-1:0] pend;
  logic [AW-1:0] addr_a [NPORTS];
  logic [DW-1:0] din_a [NPORTS];
  logic [DW-1:0] dout_a [NPORTS];
  logic [DW-1:0] mem [0:2**AW-1];
  logic [DW-1:0] ram_q;
  logic ram_we;
  jtkiwi_shram_rr #(.N(NPORTS), .PW(PW)) u_rr (
    .pend (pend),
    .ptr  (rr_ptr),
    .idx  (pick),
    .any  (any)
  );
  always_comb st_nx = st == ARB_IDLE ? (!hold && any ? ARB_ACC : ARB_IDLE) :
                      st == ARB_ACC  ? ARB_RD : ARB_IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= ARB_IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      st <= st_nx;
      if (st == ARB_IDLE && st_nx == ARB_ACC) grant <= pick;
      if (st == ARB_RD) rr_ptr <= grant == PW'(NPORTS - 1) ? '0 : grant + 1'b1;
    end
  end
  assign ram_we = st == ARB_ACC && !rnw[grant];
  always_ff @(posedge clk) begin
    if (ram_we) mem[addr_a[grant]] <= din_a[grant];
    ram_q <= mem[addr_a[grant]];
  end
  genvar i;
  generate
    for (i = 0; i < NPORTS; i++) begin : g_port
      logic fin;
      assign addr_a[i] = addr[i*AW +: AW];
      assign din_a[i]  = din[i*DW +: DW];
      assign dout[i*DW +: DW] = dout_a[i];
      assign ok[i]   = pst[i] == P_DONE;
      assign pend[i] = pst[i] == P_PEND;
      assign fin     = st == ARB_RD && grant == PW'(i);
      // a cancelled request still lets its granted access finish, but never reaches DONE
      always_comb pst_nx[i] = pst[i] == P_IDLE ? (cs[i] ? P_PEND : P_IDLE) :
                              pst[i] == P_PEND ? (!cs[i] ? P_IDLE : fin ? P_DONE : P_PEND) :
                              (cs[i] ? P_DONE : P_IDLE);
      always_ff @(posedge clk) begin
        if (rst) begin
          pst[i]    <= P_IDLE;
          dout_a[i] <= '0;
        end else begin
          pst[i] <= pst_nx[i];
          if (pst[i] == P_PEND && pst_nx[i] == P_DONE && rnw[i]) dout_a[i] <= ram_q;
        end
      end
    end
  endgenerate
`ifdef JTKIWI_SHRAM_STATS_EN
  logic [7:0] st_cnt;
  always_ff @(posedge clk) begin
    if (rst) st_cnt <= '0;
    else if ($countones(pend) >= 2 && st_cnt != 8'hFF) st_cnt <= st_cnt + 8'd1;
  end
  assign st_dout = st_cnt;
`else
  assign st_dout = '0;
`endif
endmodule

// File: tb/tb_jtkiwi_shram_arb.sv
// tb_jtkiwi_shram_arb: directed checks of latency, round-robin order, hold, cancel and reset
module tb_jtkiwi_shram_arb;
  localparam int NP = 4, AW = 13, DW = 8;
  logic clk = 0, rst, hold;
  logic [NP-1:0] cs, rnw, ok;
  logic [NP*AW-1:0] addr;
  logic [NP*DW-1:0] din, dout;
  logic [7:0] st_dout;
  int pass_cnt = 0, total = 0;
  int lat [NP];
  jtkiwi_shram_arb #(.NPORTS(NP), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .hold(hold), .cs(cs), .rnw(rnw), .addr(addr),
    .din(din), .dout(dout), .ok(ok), .st_dout(st_dout)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic setp(input int i, input bit r, input int a, input int d);
    rnw[i] = r;
    addr[i*AW +: AW] = AW'(a);
    din[i*DW +: DW] = DW'(d);
  endtask
  function automatic int dq(input int i);
    return int'(dout[i*DW +: DW]);
  endfunction
  task automatic do_rst;
    rst = 1; cs = '0; hold = 0;
    step;
    rst = 0;
  endtask
  // raise cs on the masked ports, drop each one as soon as its ok is seen
  task automatic run(input logic [NP-1:0] m);
    for (int i = 0; i < NP; i++) lat[i] = -1;
    cs = m;
    for (int n = 1; n <= 40 && cs != 0; n++) begin
      step;
      for (int i = 0; i < NP; i++)
        if (cs[i] && ok[i]) begin
          lat[i] = n - 1;
          cs[i] = 0;
        end
    end
    cs = '0;
    step;
  endtask
  initial begin
    int cnt [NP];
    int sta [NP];
    int mx, mn, mlat, seen;
    rst = 1; hold = 0; cs = '0; rnw = '0; addr = '0; din = '0;
    step; step;
    rst = 0;
    check("rst ok", int'(ok), 0);
    check("rst dout", int'(dout), 0);
    check("rst st_dout", int'(st_dout), 0);
    setp(0, 0, 'h10, 'hA5);
    run(4'b0001);
    check("t1 wr lat", lat[0], 3);
    check("t1 wr keeps dout", dq(0), 0);
    setp(0, 1, 'h10, 0);
    run(4'b0001);
    check("t1 rd lat", lat[0], 3);
    check("t1 rd dout", dq(0), 'hA5);
    check("t1 ok low", int'(ok), 0);
    do_rst;
    setp(0, 0, 'h20, 'h11);
    setp(1, 0, 'h21, 'h22);
    run(4'b0011);
    check("t2 wr lat0", lat[0], 3);
    check("t2 wr lat1", lat[1], 6);
    setp(0, 1, 'h20, 0);
    setp(1, 1, 'h21, 0);
    run(4'b0011);
    check("t2 rd lat0", lat[0], 3);
    check("t2 rd lat1", lat[1], 6);
    check("t2 dout0", dq(0), 'h11);
    check("t2 dout1", dq(1), 'h22);
    for (int i = 0; i < NP; i++) setp(i, 0, 'h30 + i, 'hC0 + i);
    run(4'b1111);
    check("t3 wr lat2", lat[2], 3);
    check("t3 wr lat3", lat[3], 6);
    check("t3 wr lat0", lat[0], 9);
    check("t3 wr lat1", lat[1], 12);
    for (int i = 0; i < NP; i++) setp(i, 1, 'h30 + i, 0);
    run(4'b1111);
    for (int i = 0; i < NP; i++) begin
      check($sformatf("t3 rd lat%0d", i), lat[i], ((i + 2) % NP) * 3 + 3);
      check($sformatf("t3 rd dout%0d", i), dq(i), 'hC0 + i);
    end
    for (int i = 0; i < NP; i++) begin cnt[i] = 0; sta[i] = 0; end
    mlat = 0;
    cs = 4'b1111;
    for (int n = 1; n <= 120; n++) begin
      step;
      for (int i = 0; i < NP; i++)
        if (cs[i] && ok[i]) begin
          cnt[i]++;
          if (n - sta[i] - 1 > mlat) mlat = n - sta[i] - 1;
          cs[i] = 0;
        end else if (!cs[i] && !ok[i]) begin
          cs[i] = 1;
          sta[i] = n;
        end
    end
    cs = '0;
    repeat (4) step;
    mx = cnt[0]; mn = cnt[0];
    for (int i = 1; i < NP; i++) begin
      if (cnt[i] > mx) mx = cnt[i];
      if (cnt[i] < mn) mn = cnt[i];
    end
    check("t3 fair spread", int'(mx - mn <= 1), 1);
    check("t3 fair served", int'(mn >= 8), 1);
    check("t3 max latency", int'(mlat <= 12), 1);
    setp(0, 0, 'h60, 'h66);
    setp(1, 1, 'h10, 0);
    cs = 4'b0001;
    step; step;
    hold = 1;
    cs[1] = 1;
    step;
    check("t4 ok0 early", int'(ok[0]), 0);
    step;
    check("t4 ok0 inflight", int'(ok[0]), 1);
    cs[0] = 0;
    seen = 0;
    repeat (5) begin step; seen |= int'(ok[1]); end
    check("t4 ok1 held", seen, 0);
    hold = 0;
    step; step;
    check("t4 ok1 before", int'(ok[1]), 0);
    step;
    check("t4 ok1 after", int'(ok[1]), 1);
    check("t4 dout1", dq(1), 'hA5);
    cs = '0;
    step;
    setp(0, 0, 'h10, 'h5A);
    setp(1, 1, 'h30, 0);
    cs[1] = 1;
    step;
    cs[0] = 1;
    step;
    cs[0] = 0;
    seen = 0;
    lat[1] = -1;
    for (int n = 3; n <= 12; n++) begin
      step;
      seen |= int'(ok[0]);
      if (cs[1] && ok[1]) begin lat[1] = n - 1; cs[1] = 0; end
    end
    cs = '0;
    check("t5 no ok0", seen, 0);
    check("t5 lat1", lat[1], 3);
    check("t5 dout1", dq(1), 'hC0);
    setp(0, 1, 'h10, 0);
    run(4'b0001);
    check("t5 cancelled write absent", dq(0), 'hA5);
    setp(2, 0, 'h40, 'h77);
    cs[2] = 1;
    step; step;
    cs[2] = 0;
    seen = 0;
    repeat (6) begin step; seen |= int'(ok[2]); end
    check("t5 granted cancel no ok", seen, 0);
    setp(2, 1, 'h40, 0);
    run(4'b0100);
    check("t5 granted write landed", dq(2), 'h77);
    setp(0, 0, 'h50, 'h99);
    cs = 4'b0001;
    step; step;
    rst = 1;
    cs = '0;
    step;
    rst = 0;
    check("t6 ok", int'(ok), 0);
    check("t6 st_dout", int'(st_dout), 0);
    check("t6 dout0", dq(0), 0);
    setp(0, 1, 'h10, 0);
    run(4'b0001);
    check("t6 rd lat", lat[0], 3);
    check("t6 old data", dq(0), 'hA5);
    hold = 1;
    cs = 4'b0011;
    repeat (300) step;
`ifdef JTKIWI_SHRAM_STATS_EN
    check("stats sat", int'(st_dout), 'hFF);
`else
    check("stats off", int'(st_dout), 0);
`endif
    do_rst;
    check("stats rst", int'(st_dout), 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
